// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC unit: default parameters and
// the encoding of the next-PC source chosen by the priority decoder.
package pc_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0;
  localparam int          DEF_STEP      = 4;

  typedef enum logic [2:0] {
    SRC_BR   = 3'd0,
    SRC_HOLD = 3'd1,
    SRC_SWAP = 3'd2,
    SRC_RET  = 3'd3,
    SRC_CALL = 3'd4,
    SRC_SEQ  = 3'd5
  } src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; empty/full flags are registered alongside the entry count.
module pc_ras
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              swap,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  tp_q, tp_d, wr_ptr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              empty_q, full_q, wr_en;

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = tp_q;
    if (push) begin
      tp_d   = tp_q + PTR_W'(1);
      wr_ptr = tp_q + PTR_W'(1);
      wr_en  = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      if (cnt_q != '0) begin
        tp_d  = tp_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (swap) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_MAX);
    end
  end

  // Entry storage is not reset; a zero count makes stale entries unreachable.
  always_ff @(negedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= wdata;
  end

  assign top   = mem_q[tp_q];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: priority next-PC selection among branch
// redirect, stall hold, call/return via the RAS, and sequential increment.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter int                STEP      = DEF_STEP,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              call_en,
  input  logic [ADDR_W-1:0] call_target,
  input  logic [ADDR_W-1:0] link_addr,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ret_miss
);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_seq, ras_top;
  logic              valid_q, miss_q, miss_d;
  logic              ras_push, ras_pop, ras_swap;
  src_e              src;

  assign pc_seq = pc_q + ADDR_W'(STEP);

  // The first edge after reset only arms pc_valid, so it is treated as a hold.
  always_comb begin
    src = SRC_SEQ;
    if (br_taken)                src = SRC_BR;
    else if (stall || !valid_q)  src = SRC_HOLD;
    else if (call_en && ret_en)  src = ras_empty ? SRC_CALL : SRC_SWAP;
    else if (ret_en)             src = SRC_RET;
    else if (call_en)            src = SRC_CALL;
  end

  always_comb begin
    pc_d     = pc_seq;
    miss_d   = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_swap = 1'b0;
    case (src)
      SRC_BR:   pc_d = br_target;
      SRC_HOLD: pc_d = pc_q;
      SRC_SWAP: begin
        pc_d     = ras_top;
        ras_swap = 1'b1;
      end
      SRC_RET: begin
        if (ras_empty) begin
          miss_d = 1'b1;
        end else begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end
      end
      SRC_CALL: begin
        pc_d     = call_target;
        ras_push = 1'b1;
      end
      default:  pc_d = pc_seq;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      miss_q  <= miss_d;
    end
  end

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .rst_n(rst_n),
    .push (ras_push),
    .pop  (ras_pop),
    .swap (ras_swap),
    .wdata(link_addr),
    .top  (ras_top),
    .empty(ras_empty),
    .full (ras_full)
  );

  assign pc       = pc_q;
  assign pc_valid = valid_q;
  assign ret_miss = miss_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table of one-cycle transactions
// plus hand-written reset sequences. State changes on falling edges.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, call_en, ret_en;
  logic [31:0] br_target, call_target, link_addr;
  logic [31:0] pc;
  logic        pc_valid, ras_empty, ras_full, ret_miss;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        st, br, ca, rt;
    logic [31:0] bt, ct, lk;
    logic [31:0] epc;
    logic        eempty, efull, emiss;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .STEP(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .call_en(call_en), .call_target(call_target),
    .link_addr(link_addr), .ret_en(ret_en), .pc(pc), .pc_valid(pc_valid),
    .ras_empty(ras_empty), .ras_full(ras_full), .ret_miss(ret_miss)
  );

  function automatic vec_t mk(logic st, logic br, logic [31:0] bt, logic ca,
                              logic [31:0] ct, logic [31:0] lk, logic rt,
                              logic [31:0] epc, logic ee, logic ef, logic em);
    vec_t v;
    v.st = st; v.br = br; v.bt = bt; v.ca = ca; v.ct = ct; v.lk = lk; v.rt = rt;
    v.epc = epc; v.eempty = ee; v.efull = ef; v.emiss = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] epc, input logic ev,
                         input logic ee, input logic ef, input logic em);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, ev});
    chk({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, ee});
    chk({tag, ".ras_full"}, {31'b0, ras_full}, {31'b0, ef});
    chk({tag, ".ret_miss"}, {31'b0, ret_miss}, {31'b0, em});
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; call_en = 0; ret_en = 0;
    br_target = '0; call_target = '0; link_addr = '0;
  endtask

  // Called at a rising edge: drive, let the falling edge update, sample at next rise.
  task automatic apply(input vec_t v, input int idx);
    stall = v.st; br_taken = v.br; br_target = v.bt;
    call_en = v.ca; call_target = v.ct; link_addr = v.lk; ret_en = v.rt;
    @(posedge clk);
    chk_all($sformatf("vec%0d", idx), v.epc, 1'b1, v.eempty, v.efull, v.emiss);
  endtask

  task automatic do_reset_release();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    chk_all("reset", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1;
  endtask

  initial begin
    //        st br bt            ca ct           lk         rt epc           ee ef em
    // T1: first edge arms valid, then sequential
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         0, 32'h4,        1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         0, 32'h8,        1, 0, 0));
    // T2: stall holds, branch overrides stall
    vecs.push_back(mk(1, 0, 0,            0, 0,           0,         0, 32'h8,        1, 0, 0));
    vecs.push_back(mk(1, 0, 0,            0, 0,           0,         0, 32'h8,        1, 0, 0));
    vecs.push_back(mk(1, 1, 32'h100,      0, 0,           0,         0, 32'h100,      1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h10,       0, 0,           0,         0, 32'h10,       1, 0, 0));
    // T3: call, wrong-path call/ret ignored, ret, ret-miss
    vecs.push_back(mk(0, 0, 0,            1, 32'h200,     32'h14,    0, 32'h200,      0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         0, 32'h204,      0, 0, 0));
    vecs.push_back(mk(1, 0, 0,            1, 32'h900,     32'h99,    0, 32'h204,      0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h300,      0, 0,           0,         1, 32'h300,      0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         1, 32'h14,       1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         1, 32'h18,       1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         0, 32'h1C,       1, 0, 0));
    // T4: five calls overflow a 4-deep stack
    vecs.push_back(mk(0, 0, 0,            1, 32'h1000,    32'hA0,    0, 32'h1000,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h1000,    32'hB0,    0, 32'h1000,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h1000,    32'hC0,    0, 32'h1000,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h1000,    32'hD0,    0, 32'h1000,     0, 1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h1000,    32'hE0,    0, 32'h1000,     0, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         1, 32'hE0,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         1, 32'hD0,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         1, 32'hC0,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         1, 32'hB0,       1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         1, 32'hB4,       1, 0, 1));
    // T5: swap on non-empty stack, call&ret on empty stack acts as call
    vecs.push_back(mk(0, 0, 0,            1, 32'h2000,    32'h40,    0, 32'h2000,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h2100,    32'h80,    1, 32'h40,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         1, 32'h80,       1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h3000,    32'h90,    1, 32'h3000,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         1, 32'h90,       1, 0, 0));
    // T5: address wrap
    vecs.push_back(mk(0, 1, 32'hFFFF_FFF8, 0, 0,          0,         0, 32'hFFFF_FFF8, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         0, 32'hFFFF_FFFC, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,           0,         0, 32'h4,        1, 0, 0));
    // call ahead of the mid-cycle reset
    vecs.push_back(mk(0, 0, 0,            1, 32'h500,     32'h44,    0, 32'h500,      0, 0, 0));

    idle_inputs();
    rst_n = 0;
    @(posedge clk);
    do_reset_release();
    foreach (vecs[i]) apply(vecs[i], i);

    // T6: asynchronous reset between edges while a call is being presented
    call_en = 1; call_target = 32'h600; link_addr = 32'h48;
    #2 rst_n = 0;
    #1 chk_all("async_rst", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    idle_inputs();
    rst_n = 1;
    @(posedge clk);
    chk_all("post_rst_first", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    chk_all("post_rst_seq", 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);

    // ret_miss pulse cleared asynchronously by reset
    ret_en = 1;
    @(posedge clk);
    chk_all("miss_set", 32'h8, 1'b1, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 0;
    #1 chk_all("miss_rst", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    idle_inputs();
    rst_n = 1;
    @(posedge clk);
    chk_all("final_first", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
